// File: rtl/random_free_cell_picker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | random_free_cell_picker                                                    |
// | Picks a pseudo-random empty cell of an N x N board (LFSR draws, then a     |
// | wrap-around scan). Optional macro: PICKER_CENTER_FIRST_EN (odd N only).    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module random_free_cell_picker #(
  parameter int          N         = 3,
  parameter int          MAX_TRIES = 4,
  parameter logic [15:0] SEED      = 16'hACE1,
  localparam int         CELLS     = N * N,
  localparam int         IW        = $clog2(N * N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*CELLS-1:0]   board,
  output logic                 busy,
  output logic                 done,
  output logic [IW-1:0]        position,
  output logic                 none_free
);

  localparam logic [2:0] c_idle  = 3'd0;
  localparam logic [2:0] c_draw  = 3'd1;
  localparam logic [2:0] c_check = 3'd2;
  localparam logic [2:0] c_scan  = 3'd3;
  localparam logic [2:0] c_done  = 3'd4;

`ifdef PICKER_CENTER_FIRST_EN
  localparam bit c_center_en = ((N % 2) == 1);
`else
  localparam bit c_center_en = 1'b0;
`endif

  logic [2:0]         r_state;
  logic [2:0]         w_next;
  logic [15:0]        r_lfsr;
  logic [2*CELLS-1:0] r_snap;
  logic [IW-1:0]      r_cand;
  logic [IW-1:0]      r_pos;
  logic [3:0]         r_tries;
  logic               r_none;
  logic [CELLS-1:0]   w_free;
  logic               w_any_free;
  logic               w_cand_free;
  logic [15:0]        w_mod;
  logic [IW-1:0]      w_draw;
  logic [IW-1:0]      w_cand_inc;
  logic               w_feedback;

  for (genvar gi = 0; gi < CELLS; gi++) begin : g_free
    assign w_free[gi] = (r_snap[2*gi +: 2] == 2'b00);
  end

  assign w_any_free  = |w_free;
  assign w_cand_free = w_free[r_cand];
  assign w_mod       = r_lfsr % 16'(CELLS);
  // The very first draw of a pick (tries still zero) may be forced to the center.
  assign w_draw      = (c_center_en && (r_tries == 4'd0)) ? IW'(CELLS / 2) : IW'(w_mod);
  assign w_cand_inc  = (r_cand == IW'(CELLS - 1)) ? '0 : r_cand + IW'(1);
  assign w_feedback  = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  // Free-running LFSR; never restarted by start, so successive picks differ.
  always_ff @(posedge clk) begin
    if (rst) r_lfsr <= SEED;
    else     r_lfsr <= {w_feedback, r_lfsr[15:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= c_idle;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle:  if (start) w_next = c_draw;
      c_draw:  w_next = w_any_free ? c_check : c_done;
      c_check: begin
        if (w_cand_free)                    w_next = c_done;
        else if (r_tries < 4'(MAX_TRIES))   w_next = c_draw;
        else                                w_next = c_scan;
      end
      c_scan:  if (w_cand_free) w_next = c_done;
      c_done:  w_next = c_idle;
      default: w_next = c_idle;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      c_draw, c_check, c_scan: busy = 1'b1;
      c_done:                  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap  <= '0;
      r_cand  <= '0;
      r_pos   <= '0;
      r_tries <= '0;
      r_none  <= 1'b0;
    end else begin
      case (r_state)
        c_idle: if (start) begin
          r_snap  <= board;
          r_tries <= '0;
          r_none  <= 1'b0;
        end
        c_draw: begin
          if (!w_any_free) begin
            r_none <= 1'b1;
            r_pos  <= '0;
          end else begin
            r_cand  <= w_draw;
            r_tries <= r_tries + 4'd1;
          end
        end
        c_check: begin
          if (w_cand_free)                      r_pos  <= r_cand;
          else if (r_tries >= 4'(MAX_TRIES))    r_cand <= w_cand_inc;
        end
        c_scan: begin
          if (w_cand_free) r_pos  <= r_cand;
          else             r_cand <= w_cand_inc;
        end
        default: ;
      endcase
    end
  end

  assign position  = r_pos;
  assign none_free = r_none;

endmodule
`default_nettype wire

// File: tb/tb_random_free_cell_picker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_random_free_cell_picker                                                 |
// | Directed, table-driven bench for random_free_cell_picker with N = 3.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_random_free_cell_picker;

  localparam int CELLS = 9;
  localparam int IW    = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [2*CELLS-1:0] board;
  logic              busy;
  logic              done;
  logic [IW-1:0]     position;
  logic              none_free;

  int n_chk = 0;
  int n_err = 0;

  random_free_cell_picker dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .board     (board),
    .busy      (busy),
    .done      (done),
    .position  (position),
    .none_free (none_free)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] brd;
    logic        nf;
    int          pos;
    logic        fixed;
    int          lat_exact;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [17:0] build(input logic [8:0] fm, input logic [1:0] fill);
    logic [17:0] r;
    for (int i = 0; i < 9; i++) r[2*i +: 2] = fm[i] ? 2'b00 : fill;
    return r;
  endfunction

  // lat = cycles from the accepting edge to done (0 on timeout).
  task automatic pick(input logic [17:0] b, output int lat, output int pos,
                      output logic nf, output logic busy_ok);
    @(negedge clk);
    board = b;
    start = 1'b1;
    @(posedge clk);
    lat     = 0;
    busy_ok = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat = c;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    pos = int'(position);
    nf  = none_free;
  endtask

  vec_t v[10];

  initial begin
    int   lat;
    int   pos;
    logic nf;
    logic bok;
    int   cnt[9];
    int   bad;
    logic [17:0] b;

    v[0] = '{build(9'h000, 2'b01), 1'b1, 0, 1'b1, 2};
    v[1] = '{build(9'h000, 2'b10), 1'b1, 0, 1'b1, 2};
    v[2] = '{build(9'h000, 2'b11), 1'b1, 0, 1'b1, 2};
    v[3] = '{build(9'h080, 2'b10), 1'b0, 7, 1'b1, 0};
    v[4] = '{build(9'h001, 2'b01), 1'b0, 0, 1'b1, 0};
    v[5] = '{build(9'h100, 2'b11), 1'b0, 8, 1'b1, 0};
    v[6] = '{build(9'h010, 2'b01), 1'b0, 4, 1'b1, 0};
    v[7] = '{build(9'h024, 2'b10), 1'b0, 0, 1'b0, 0};
`ifdef PICKER_CENTER_FIRST_EN
    v[8] = '{build(9'h1FF, 2'b01), 1'b0, 4, 1'b1, 3};
`else
    v[8] = '{build(9'h1FF, 2'b01), 1'b0, 0, 1'b0, 3};
`endif
    v[9] = '{build(9'h1EF, 2'b01), 1'b0, 0, 1'b0, 0};

    rst   = 1'b1;
    start = 1'b0;
    board = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_position", int'(position), 0);
    chk("reset_none_free", int'(none_free), 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      pick(v[i].brd, lat, pos, nf, bok);
      chk($sformatf("vec%0d_timeout", i), int'(lat != 0), 1);
      if (v[i].lat_exact != 0) chk($sformatf("vec%0d_latency", i), lat, v[i].lat_exact);
      else                     chk($sformatf("vec%0d_latency_le18", i), int'(lat <= 18), 1);
      chk($sformatf("vec%0d_none_free", i), int'(nf), int'(v[i].nf));
      if (v[i].fixed) chk($sformatf("vec%0d_position", i), pos, v[i].pos);
      if (!v[i].nf) chk($sformatf("vec%0d_cell_empty", i),
                        int'(pos < 9 && v[i].brd[2*pos +: 2] == 2'b00), 1);
      chk($sformatf("vec%0d_busy_window", i), int'(bok), 1);
      @(negedge clk);
      chk($sformatf("vec%0d_done_one_cycle", i), int'(done), 0);
    end

    // Single free cell at 7: every pick must land there within the bound.
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      pick(build(9'h080, 2'b10), lat, pos, nf, bok);
      if (pos != 7 || nf || lat == 0 || lat > 18) bad++;
    end
    chk("single7_x50_bad_picks", bad, 0);

`ifndef PICKER_CENTER_FIRST_EN
    for (int i = 0; i < 9; i++) cnt[i] = 0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      pick(build(9'h1FF, 2'b00), lat, pos, nf, bok);
      if (lat != 3 || pos > 8 || nf) bad++;
      else cnt[pos]++;
    end
    chk("empty_x1000_bad_picks", bad, 0);
    for (int i = 0; i < 9; i++)
      chk($sformatf("empty_hist_idx%0d_ge60 (count %0d)", i, cnt[i]), int'(cnt[i] >= 60), 1);
`endif

    // Board toggles and start held high through busy and the done cycle.
    @(negedge clk);
    board = build(9'h080, 2'b10);
    start = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      board = (c % 2 == 1) ? build(9'h1FF, 2'b00) : build(9'h000, 2'b01);
      if (done) begin
        lat = c;
        break;
      end
    end
    chk("snapshot_position", int'(position), 7);
    chk("snapshot_none_free", int'(none_free), 0);
    chk("snapshot_latency_le18", int'(lat != 0 && lat <= 18), 1);
    @(negedge clk);
    chk("start_in_done_ignored", int'(busy), 0);
    start = 1'b0;
    @(negedge clk);
    chk("no_restart_busy", int'(busy), 0);
    chk("no_restart_done", int'(done), 0);

    // Reset in the middle of a pick aborts it without a done pulse.
    @(negedge clk);
    board = build(9'h080, 2'b10);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("midreset_busy_before", int'(busy), 1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_done", int'(done), 0);
    chk("midreset_position", int'(position), 0);
    chk("midreset_none_free", int'(none_free), 0);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done || busy) bad++;
    end
    chk("midreset_no_done_after", bad, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/random_free_cell_picker.md
# random_free_cell_picker

Parametrised successor to the tic-tac-toe CPU move picker: selects a uniformly pseudo-random empty cell on an N×N board and returns its linear index through a start/done handshake. A free-running 16-bit LFSR draws candidates. After a bounded number of failed draws, a wrap-around linear scan guarantees termination. A full board is reported explicitly. Sits between the game-state register and the move-commit logic of the CPU player.

## Interface

Parameters:

- N, default 3: board side. Legal range 2..8. CELLS = N*N. IW = $clog2(CELLS).
- MAX_TRIES, default 4: random draws before falling back to the scan. Legal range 1..15.
- SEED, default 16'hACE1: LFSR reset value. Must be nonzero.

Ports:

- clk, input, 1: clock.
- rst, input, 1: reset. Synchronous, active-high.
- start, input, 1: request a pick. Sampled only in IDLE.
- board, input, CELLS*2: cell i occupies bits [2i+1:2i]. 2'b00 = empty, 2'b01 = player, 2'b10 = CPU, 2'b11 = invalid (treated as occupied).
- busy, output, 1: high from the cycle after start is accepted until done.
- done, output, 1: one-cycle pulse when the result is valid.
- position, output, IW: chosen index 0..CELLS-1. Held until the next accepted start.
- none_free, output, 1: set with done when no empty cell exists. Held like position.

## Operation

- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. Shifts every cycle in every state and is not reset by start.
- Snapshot: board is registered into snap on the cycle start is accepted. Board changes during busy are ignored.
- FSM states: IDLE, DRAW, CHECK, SCAN, DONE.
- IDLE:
  - start=1 → capture snap, clear tries, none_free←0 → DRAW.
- DRAW:
  - If snap has no empty cell → none_free←1, position←0 → DONE.
  - Otherwise cand←lfsr % CELLS (unsigned 16-bit modulo), tries←tries+1 → CHECK.
- CHECK:
  - snap[cand] == 00 → position←cand → DONE.
  - Else if tries < MAX_TRIES → DRAW.
  - Else cand←(cand+1) wrapping at CELLS → SCAN.
- SCAN, one cell per cycle:
  - snap[cand] == 00 → position←cand → DONE.
  - Else cand←(cand+1), CELLS-1 wraps to 0.
  - Termination is guaranteed because DRAW already proved at least one free cell exists.
- DONE: done=1 for exactly one cycle, busy=0 → IDLE.
- start while not in IDLE is ignored, not queued. start in the DONE cycle is also ignored.
- Reset:
  - FSM to IDLE, lfsr←SEED.
  - busy=0, done=0, position=0, none_free=0, tries=0, cand=0.
  - Reset mid-operation aborts the pick with no done pulse.

## Timing

- start accepted at cycle t → busy=1 at t+1.
- Full board: done at t+2.
- First draw hits: done at t+3.
- k-th draw hits: done at t+1+2k.
- Worst case: done ≤ t+2*MAX_TRIES+CELLS+1. With defaults, ≤ t+18.
- busy falls in the same cycle done rises. A new start is accepted at the earliest in the cycle after done.
- position and none_free update in the cycle done rises and are stable while done=1.

## Configuration

- PICKER_CENTER_FIRST_EN defined, and N odd:
  - The first DRAW of each pick takes cand = CELLS/2 (integer division) instead of the LFSR value.
  - If that cell is free, done arrives at t+3 with position = center.
  - Otherwise the normal flow continues; that first draw counts toward MAX_TRIES.
- Defined with N even: no effect.
- Not defined: every draw comes from the LFSR.

## Test plan

- Reset: assert rst for 2 cycles during busy → busy=0, done=0, position=0, none_free=0. No done pulse follows.
- Full board (all cells 2'b01), start at t → done at t+2, none_free=1, position=0, busy high only at t+1.
- Single free cell at index 7 (N=3), others 2'b10 → position=7, none_free=0, done ≤ t+18. Repeat 50 picks; every result is 7.
- Empty board, 1000 picks, macro undefined → every position in 0..8. Each index appears at least 60 times. done always at t+3.
- With PICKER_CENTER_FIRST_EN and an empty board → position=4, done at t+3. With cell 4 = 2'b01 → position ≠ 4.
- Toggle board and pulse start during busy → result matches the snapshot taken at acceptance; the extra start does not extend or restart the pick.
